// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer
//   Drives an external posedge set/reset flip-flop from level requests.
//   Each accepted request produces a single s or r pulse PULSE_W cycles
//   wide, followed by a GAP_W-cycle recovery gap. At the end of the gap the
//   flip-flop's q feedback is checked against the requested level. A shadow
//   copy of the committed level suppresses redundant pulses.
//
// Ports
//   clk           clock, all state changes on the rising edge
//   rst           synchronous active-high reset
//   req_valid     level request presented
//   req_level     requested level (1 = set, 0 = reset)
//   req_ready     request can be accepted this cycle
//   s, r          registered set/reset drives, never both high
//   q_fb          q returned from the driven flip-flop
//   shadow_q      last level committed by this block
//   shadow_known  shadow_q is valid
//   busy          a command is in progress
//   done          one-cycle completion strobe
//   mismatch      sticky q_fb disagreement flag, cleared only by rst

module sr_drive_sequencer #(
    parameter int unsigned PULSE_W = 1,
    parameter int unsigned GAP_W   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic s,
    output logic r,
    input  logic q_fb,
    output logic shadow_q,
    output logic shadow_known,
    output logic busy,
    output logic done,
    output logic mismatch
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               target_q, target_d;
    logic               s_q, s_d;
    logic               r_q, r_d;
    logic               shadow_q_q, shadow_q_d;
    logic               shadow_known_q, shadow_known_d;
    logic               done_q, done_d;
    logic               mismatch_q, mismatch_d;

    // State register; reset overrides any request presented at the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            target_q       <= 1'b0;
            s_q            <= 1'b0;
            r_q            <= 1'b0;
            shadow_q_q     <= 1'b0;
            shadow_known_q <= 1'b0;
            done_q         <= 1'b0;
            mismatch_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            s_q            <= s_d;
            r_q            <= r_d;
            shadow_q_q     <= shadow_q_d;
            shadow_known_q <= shadow_known_d;
            done_q         <= done_d;
            mismatch_q     <= mismatch_d;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        target_d       = target_q;
        s_d            = 1'b0;
        r_d            = 1'b0;
        shadow_q_d     = shadow_q_q;
        shadow_known_d = shadow_known_q;
        done_d         = 1'b0;
        mismatch_d     = mismatch_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (shadow_known_q && (req_level == shadow_q_q)) begin
                        // Flip-flop already holds this level: complete without a pulse
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_PULSE;
                        target_d = req_level;
                        cnt_d    = CNT_W'(PULSE_W - 1);
                        s_d      = req_level;
                        r_d      = ~req_level;
                    end
                end
            end

            ST_PULSE: begin
                if (cnt_q == '0) begin
                    // Last drive cycle: release both lines and start the gap
                    state_d = ST_GAP;
                    cnt_d   = CNT_W'(GAP_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    s_d   = target_q;
                    r_d   = ~target_q;
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    // End of recovery gap: verify feedback and commit the shadow
                    state_d        = ST_IDLE;
                    mismatch_d     = mismatch_q | (q_fb != target_q);
                    shadow_q_d     = target_q;
                    shadow_known_d = 1'b1;
                    done_d         = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready    = (state_q == ST_IDLE) && !rst;
    assign busy         = (state_q != ST_IDLE);
    assign s            = s_q;
    assign r            = r_q;
    assign shadow_q     = shadow_q_q;
    assign shadow_known = shadow_known_q;
    assign done         = done_q;
    assign mismatch     = mismatch_q;

endmodule

// File: tb/tb_sr_drive_sequencer.sv
module tb_sr_drive_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic req_valid;
    logic req_level;
    logic req_ready;
    logic s;
    logic r;
    logic q_fb;
    logic shadow_q;
    logic shadow_known;
    logic busy;
    logic done;
    logic mismatch;

    logic ff_q = 1'b0;
    logic force_q0;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int done_cyc;
        bit shq;
        bit mism;
    } exp_t;

    exp_t exp_q[$];
    bit   exp_s[int];
    bit   exp_r[int];

    sr_drive_sequencer #(
        .PULSE_W(2),
        .GAP_W  (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_level   (req_level),
        .req_ready   (req_ready),
        .s           (s),
        .r           (r),
        .q_fb        (q_fb),
        .shadow_q    (shadow_q),
        .shadow_known(shadow_known),
        .busy        (busy),
        .done        (done),
        .mismatch    (mismatch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural posedge SR flip-flop, powers up at 0
    always @(posedge clk) begin
        if (s)      ff_q <= 1'b1;
        else if (r) ff_q <= 1'b0;
    end

    assign q_fb = force_q0 ? 1'b0 : ff_q;

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp);
        end
    endtask

    // Wait (bounded) at negedges until the DUT will accept a request
    task automatic wait_ready(output bit ok);
        int t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        ok = req_ready;
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL ready_timeout cyc=%0d got=0 exp=1", cyc);
        end
    endtask

    // Issue one request; expected pulse and completion are hand-supplied
    task automatic issue(input bit lvl, input bit red, input bit shq, input bit mism);
        bit ok;
        int c0;
        wait_ready(ok);
        if (ok) begin
            req_valid = 1'b1;
            req_level = lvl;
            c0 = cyc;
            if (!red) begin
                if (lvl) begin
                    exp_s[c0+1] = 1'b1;
                    exp_s[c0+2] = 1'b1;
                end else begin
                    exp_r[c0+1] = 1'b1;
                    exp_r[c0+2] = 1'b1;
                end
            end
            exp_q.push_back('{c0 + (red ? 1 : 4), shq, mism});
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Monitor: per-cycle drive check plus done-event scoreboard
    logic es;
    logic er;
    exp_t e;
    always @(negedge clk) begin
        es = exp_s.exists(cyc) ? exp_s[cyc] : 1'b0;
        er = exp_r.exists(cyc) ? exp_r[cyc] : 1'b0;
        chk("s_drive", s, es);
        chk("r_drive", r, er);
        chk("s_r_exclusive", s & r, 1'b0);
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", done, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk_int("done_cycle", cyc, e.done_cyc);
                chk("done_shadow_q", shadow_q, e.shq);
                chk("done_shadow_known", shadow_known, 1'b1);
                chk("done_mismatch", mismatch, e.mism);
                chk("done_ready", req_ready, 1'b1);
            end
        end else if (exp_q.size() > 0 && exp_q[0].done_cyc <= cyc) begin
            e = exp_q.pop_front();
            chk_int("missed_done", cyc, e.done_cyc);
        end
    end

    initial begin
        bit ok;
        int c0;
        bit lvl;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_level = 1'b0;
        force_q0  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready_low", req_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_shadow_known", shadow_known, 1'b0);
        chk("rst_shadow_q", shadow_q, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_mismatch", mismatch, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", req_ready, 1'b1);
        @(negedge clk);

        // Basic set from unknown shadow
        issue(1'b1, 1'b0, 1'b1, 1'b0);
        chk("busy_in_pulse", busy, 1'b1);
        chk("ready_in_pulse", req_ready, 1'b0);

        // Redundant set, then reset accepted in the redundant done cycle
        issue(1'b1, 1'b1, 1'b1, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 1'b0);

        // Forced bad feedback during a set; mismatch stays sticky afterwards
        wait_ready(ok);
        force_q0 = 1'b1;
        issue(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        force_q0 = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 1'b1);
        issue(1'b1, 1'b0, 1'b1, 1'b1);
        issue(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset during cycle 2 of a set pulse
        wait_ready(ok);
        req_valid = 1'b1;
        req_level = 1'b1;
        c0 = cyc;
        exp_s[c0+1] = 1'b1;
        exp_s[c0+2] = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_shadow_known", shadow_known, 1'b0);
        chk("midrst_shadow_q", shadow_q, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_mismatch", mismatch, 1'b0);
        chk("midrst_ready_in_rst", req_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_after", req_ready, 1'b1);
        repeat (6) @(negedge clk);

        // Reset and request at the same edge: reset wins
        rst       = 1'b1;
        req_valid = 1'b1;
        req_level = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("same_edge_busy", busy, 1'b0);
        chk("same_edge_shadow_known", shadow_known, 1'b0);
        @(negedge clk);
        chk("same_edge_busy2", busy, 1'b0);
        chk("same_edge_done", done, 1'b0);
        chk("same_edge_mismatch", mismatch, 1'b0);
        chk("same_edge_shadow_q", shadow_q, 1'b0);

        // Continuous req_valid with toggling level: one accept every 4 cycles
        req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            lvl = ((k & 1) == 0);
            req_level = lvl;
            c0 = cyc;
            if (lvl) begin
                exp_s[c0+1] = 1'b1;
                exp_s[c0+2] = 1'b1;
            end else begin
                exp_r[c0+1] = 1'b1;
                exp_r[c0+2] = 1'b1;
            end
            exp_q.push_back('{c0 + 4, lvl, 1'b0});
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                req_level = ~req_level;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;

        repeat (8) @(negedge clk);
        chk_int("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_drive_sequencer.md
# sr_drive_sequencer

Command-side driver for an external set/reset flip-flop: it turns level requests into clean, width-controlled `s`/`r` pulses, never drives the forbidden `s=r=1` combination, and enforces a recovery gap between commands. It keeps a shadow copy of the flip-flop state and verifies the flip-flop's `q` feedback after each command. It sits between control logic that wants a level and any posedge SR flip-flop (`s`,`r`,`clk`,`q`) on the same clock.

## Interface
Parameters:
- `PULSE_W`, default 1: cycles `s` or `r` is held high per command; legal range 1..255.
- `GAP_W`, default 1: idle cycles after a pulse before `q_fb` is checked; legal range 1..255.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  a level request is presented.
- `req_level`  in  1  requested flip-flop level (1 = set, 0 = reset).
- `req_ready`  out  1  block can accept a request.
- `s`  out  1  set drive to the flip-flop (registered).
- `r`  out  1  reset drive to the flip-flop (registered).
- `q_fb`  in  1  `q` returned from the driven flip-flop.
- `shadow_q`  out  1  last level this block committed.
- `shadow_known`  out  1  `shadow_q` is valid.
- `busy`  out  1  a command is in progress.
- `done`  out  1  one-cycle strobe: a request has completed.
- `mismatch`  out  1  sticky: `q_fb` disagreed with the target at a check.

## Operation
- States: IDLE, PULSE, GAP. `busy` = state != IDLE. `req_ready` = (state == IDLE) and not `rst`.
- Reset values, applied at the edge where `rst` is high: state IDLE, `s`=0, `r`=0, `shadow_q`=0, `shadow_known`=0, `done`=0, `mismatch`=0. Cycle counters are cleared.
- A request is accepted when `req_valid` and `req_ready` are both high at an edge. `req_level` is captured into the target at that edge. Later changes to `req_level` are ignored.
- Redundant request: if `shadow_known`=1 and `req_level`=`shadow_q`, no pulse is driven. `done`=1 for the next cycle. State stays IDLE. `mismatch` is not evaluated.
- Otherwise IDLE→PULSE:
  - Target 1 drives `s`=1, `r`=0.
  - Target 0 drives `r`=1, `s`=0.
  - The drive is held for exactly PULSE_W cycles.
- PULSE→GAP: `s`=`r`=0 for GAP_W cycles.
- At the edge that ends the last GAP cycle, `q_fb` is sampled:
  - `mismatch` <= `mismatch` | (`q_fb` != target).
  - `shadow_q` <= target; `shadow_known` <= 1.
  - `done` <= 1 for one cycle; state returns to IDLE.
- `s` and `r` are never both 1, in any state, including across reset.
- `req_valid` while busy is ignored. Requests are not queued.
- `mismatch` clears only on `rst`.

## Timing
- Acceptance edge = cycle 0.
- Drive (`s` or `r`) is high in cycles 1..PULSE_W.
- Gap occupies cycles PULSE_W+1..PULSE_W+GAP_W.
- In cycle PULSE_W+GAP_W+1: `done`, `shadow_q`, `shadow_known` and `mismatch` show their updated values, and `req_ready`=1.
- A new request may be accepted in the same cycle `done` is high, which gives back-to-back throughput of one command per PULSE_W+GAP_W+1 cycles.
- Redundant request: `done` is high in cycle 1, `req_ready` stays high, and a new request can be accepted in cycle 1.
- `rst` mid-PULSE or mid-GAP: at that edge `s`/`r` drop to 0 and all outputs take their reset values. No `done` is issued. `shadow_known`=0 because the pulse may have been truncated.
- `rst` and `req_valid` at the same edge: reset wins and the request is not accepted.

## Test plan
Benches use PULSE_W=2, GAP_W=1, with `q_fb` driven by a behavioural posedge SR flip-flop that powers up at 0.
- After reset, request level 1 at cycle 0 -> `s`=1 in cycles 1–2, `s`=`r`=0 in cycle 3, `done`=1 with `shadow_q`=1, `shadow_known`=1, `mismatch`=0 in cycle 4.
- Request 1 again, then 0 accepted in the `done` cycle -> first completes with no pulse (`done` in cycle 1). Second drives `r`=1 for 2 cycles and ends with `shadow_q`=0.
- Force `q_fb`=0 during a set request -> `mismatch`=1 in cycle 4. It stays 1 through later clean commands until `rst`.
- Hold `req_valid`=1 with toggling `req_level` continuously -> accepted requests are spaced exactly 4 cycles apart. A checker confirms `s`&`r` is never 1.
- Assert `rst` in cycle 2 of a set pulse -> `s`=0 in cycle 3, no `done`, `shadow_known`=0, `req_ready`=1 once `rst` is low.
- Request with `req_valid` and `rst` both high at the same edge -> no pulse, and the outputs remain at reset values.
